// File: rtl/fetch_unit.sv
// Program counter, lookahead instruction-memory address and Instruction Register for the LabB processor.
// Optional sticky breakpoint flag is built only when FETCH_BRK_EN is defined.
module fetch_unit #(
  parameter int PC_W  = 7,
  parameter int IR_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PC_clr,
  input  logic             PC_inc,
  input  logic             IR_ld,
  input  logic [IR_W-1:0]  I_data,
  input  logic [PC_W-1:0]  Brk_addr,
  output logic [PC_W-1:0]  I_addr,
  output logic [PC_W-1:0]  PC,
  output logic [IR_W-1:0]  IR,
  output logic             IR_valid,
  output logic [CNT_W-1:0] FetchCnt,
  output logic             Brk_hit
);

  logic [PC_W-1:0] pc_next;

  // The ROM registers I_addr on the same edge PC takes pc_next, so I_data always tracks ROM[PC].
  always_comb begin
    pc_next = PC;
    if (Reset || PC_clr) begin
      pc_next = '0;
    end else if (PC_inc) begin
      pc_next = PC + PC_W'(1);
    end
  end

  assign I_addr = pc_next;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC <= '0;
    end else begin
      PC <= pc_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      IR <= '0;
    end else if (IR_ld) begin
      IR <= I_data;
    end
  end

  // A load in the same cycle as PC_clr counts as the first fetch after the clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      IR_valid <= 1'b0;
      FetchCnt <= '0;
    end else if (PC_clr) begin
      IR_valid <= IR_ld;
      FetchCnt <= IR_ld ? CNT_W'(1) : '0;
    end else if (IR_ld) begin
      IR_valid <= 1'b1;
      if (FetchCnt != '1) begin
        FetchCnt <= FetchCnt + CNT_W'(1);
      end
    end
  end

`ifdef FETCH_BRK_EN
  always_ff @(posedge Clk) begin
    if (Reset || PC_clr) begin
      Brk_hit <= 1'b0;
    end else if (IR_ld && (PC == Brk_addr)) begin
      Brk_hit <= 1'b1;
    end
  end
`else
  logic unused_brk_addr;
  assign unused_brk_addr = ^Brk_addr;
  assign Brk_hit         = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random control traffic,
// compared every cycle against a cycle-level behavioural model of PC/IR/counter/breakpoint.
module tb_fetch_unit;

  localparam int PC_W  = 7;
  localparam int IR_W  = 16;
  localparam int CNT_W = 16;
  localparam int DEPTH = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             Clk;
  logic             Reset;
  logic             PC_clr;
  logic             PC_inc;
  logic             IR_ld;
  logic [IR_W-1:0]  I_data;
  logic [PC_W-1:0]  Brk_addr;
  logic [PC_W-1:0]  I_addr;
  logic [PC_W-1:0]  PC;
  logic [IR_W-1:0]  IR;
  logic             IR_valid;
  logic [CNT_W-1:0] FetchCnt;
  logic             Brk_hit;

  fetch_unit #(.PC_W(PC_W), .IR_W(IR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .PC_clr(PC_clr), .PC_inc(PC_inc), .IR_ld(IR_ld),
    .I_data(I_data), .Brk_addr(Brk_addr), .I_addr(I_addr), .PC(PC), .IR(IR),
    .IR_valid(IR_valid), .FetchCnt(FetchCnt), .Brk_hit(Brk_hit)
  );

  // clock / reset block
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // registered-read instruction ROM
  logic [IR_W-1:0] rom [DEPTH];
  always @(posedge Clk) I_data <= rom[I_addr];

  // behavioural reference model
  int m_pc, m_ir, m_valid, m_cnt, m_brk;
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next_pc(input logic rst, input logic clr, input logic inc);
    if (rst || clr) return 0;
    if (inc) return (m_pc + 1) % DEPTH;
    return m_pc;
  endfunction

  function automatic void model_step(input logic rst, input logic clr, input logic inc, input logic ld);
    int npc;
    npc = model_next_pc(rst, clr, inc);
    if (rst) begin
      m_ir = 0; m_valid = 0; m_cnt = 0; m_brk = 0;
    end else begin
`ifdef FETCH_BRK_EN
      if (clr) m_brk = 0;
      else if (ld && m_pc == int'(Brk_addr)) m_brk = 1;
`else
      m_brk = 0;
`endif
      if (ld) m_ir = int'(rom[m_pc]);
      if (clr) begin
        m_valid = ld ? 1 : 0;
        m_cnt   = ld ? 1 : 0;
      end else if (ld) begin
        m_valid = 1;
        if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      end
    end
    m_pc = npc;
  endfunction

  // driver: apply inputs, check lookahead address, clock, check registered state
  task automatic do_cycle(input logic rst, input logic clr, input logic inc, input logic ld);
    Reset = rst; PC_clr = clr; PC_inc = inc; IR_ld = ld;
    #1;
    check("i_addr", 32'(I_addr), 32'(model_next_pc(rst, clr, inc)));
    @(posedge Clk);
    model_step(rst, clr, inc, ld);
    #1;
    check("pc",        32'(PC),       32'(m_pc));
    check("ir",        32'(IR),       32'(m_ir));
    check("ir_valid",  32'(IR_valid), 32'(m_valid));
    check("fetch_cnt", 32'(FetchCnt), 32'(m_cnt));
    check("brk_hit",   32'(Brk_hit),  32'(m_brk));
  endtask

  initial begin
    m_pc = 0; m_ir = 0; m_valid = 0; m_cnt = 0; m_brk = 0;
    Reset = 1'b1; PC_clr = 1'b0; PC_inc = 1'b0; IR_ld = 1'b0; Brk_addr = 7'd3;
    for (int i = 0; i < DEPTH; i++) rom[i] = IR_W'($urandom);
    rom[0] = 16'h3120;
    rom[1] = 16'h2054;
    rom[9] = 16'h4ABC;

    // reset dominates increment and load
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    do_cycle(1'b1, 1'b0, 1'b1, 1'b1);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_ir", 32'(IR), 32'h0);
    check("rst_cnt", 32'(FetchCnt), 32'h0);

    // basic fetch / decode sequence
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_ir0", 32'(IR), 32'h3120);
    check("seq_pc0", 32'(PC), 32'h0);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("seq_ir1", 32'(IR), 32'h2054);
    check("seq_pc1", 32'(PC), 32'h1);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("seq_pc2", 32'(PC), 32'h2);
    check("seq_cnt", 32'(FetchCnt), 32'h2);

    // wrap at the top of the address space, clear beats increment
    for (int i = 0; i < DEPTH - 3; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("pc_top", 32'(PC), 32'h7F);
    do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("pc_wrap", 32'(PC), 32'h0);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
    check("clr_over_inc", 32'(PC), 32'h0);

    // load together with clear after nine fetches
    for (int i = 0; i < 9; i++) do_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    check("cnt9", 32'(FetchCnt), 32'd9);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("ld_clr_ir", 32'(IR), 32'h4ABC);
    check("ld_clr_cnt", 32'(FetchCnt), 32'h1);
    check("ld_clr_pc", 32'(PC), 32'h0);

    // breakpoint at address 3
    Brk_addr = 7'd3;
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      do_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
`ifdef FETCH_BRK_EN
    check("brk_set", 32'(Brk_hit), 32'h1);
`else
    check("brk_off", 32'(Brk_hit), 32'h0);
`endif
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("brk_clr", 32'(Brk_hit), 32'h0);
    Brk_addr = 7'd0;
    do_cycle(1'b0, 1'b1, 1'b0, 1'b1);
    check("brk_clr_ld", 32'(Brk_hit), 32'h0);

    // random controller traffic
    for (int i = 0; i < 400; i++) begin
      Brk_addr = PC_W'($urandom_range(0, 15));
      do_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // counter saturation
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < CNT_MAX; i++) do_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    check("cnt_full", 32'(FetchCnt), 32'hFFFF);
    do_cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("cnt_sat", 32'(FetchCnt), 32'hFFFF);
    do_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("cnt_clr", 32'(FetchCnt), 32'h0);
    check("valid_clr", 32'(IR_valid), 32'h0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
